unified_mem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the CPU fetch stage (IF port) and the memory stage (D port), so that one image serves both instruction and data space.
- Sits between the pipeline and a single RAM instance.
- Serialises accesses, returns read data with a valid pulse, and drives per-port stall signals into the hazard logic.

---
 rtl/cpu_mem_pkg.sv | 22 ++
 rtl/arb_starve_counter.sv | 50 +++++
 rtl/unified_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared types and constants for the unified instruction/data memory arbiter:
//   - arb_state_e : arbiter FSM states (IDLE / WAIT_IF / WAIT_D)
//   - PORT_IF/D   : port identifiers used when naming the arbitration winner
//   - DEF_*_WIDTH : default address and data widths
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IF = 2'd1,
        ST_WAIT_D  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Saturating up-counter with synchronous clear. Counts how many times in a row
// the D port has beaten a waiting IF port; at_limit_o tells the arbiter to hand
// the next grant to IF.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   inc_i      in   count one more D win over a waiting IF request
//   clr_i      in   clear the count (IF granted or IF not requesting)
//   at_limit_o out  count has reached LIMIT
// -----------------------------------------------------------------------------
module arb_starve_counter #(
    parameter int LIMIT = 4,
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        // NOTE: assign a default before any branch so every path drives cnt_d; otherwise a latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port synchronous RAM between the fetch (IF) port and the
// memory-stage (D) port. One transaction is in flight at a time; read data is
// registered and announced with a one-cycle valid pulse, and each port gets a
// combinational stall for the hazard logic.
// Ports:
//   clk, reset                  clock / async active-high reset
//   if_req, if_addr             fetch request (held until if_valid)
//   if_rdata, if_valid, if_stall fetch result, completion pulse, stall
//   d_req, d_we, d_addr, d_wdata data request (held until d_valid)
//   d_rdata, d_valid, d_stall   load result, completion pulse, stall
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata  RAM interface
// -----------------------------------------------------------------------------
module unified_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  d_stall,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [2:0] LAT_C = 3'(LATENCY);

    arb_state_e            state_q, state_d;
    logic [2:0]            lat_q, lat_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic                  wr_q, wr_d;      // in-flight D access is a write
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  d_valid_q, d_valid_d;

    logic arb_ok;
    logic grant;
    logic winner;
    logic starve_hit;
    logic starve_inc;
    logic starve_clr;

    // The completion cycle is spent in IDLE, but a request still high there
    // belongs to the transaction that is finishing, so it must not be granted.
    assign arb_ok = (state_q == ST_IDLE) && !if_valid_q && !d_valid_q;
    assign grant  = arb_ok && (if_req || d_req);

    // D normally wins; IF takes over once it has been passed over STARVE_LIMIT times.
    assign winner = (d_req && !(if_req && starve_hit)) ? PORT_D : PORT_IF;

    assign starve_inc = grant && (winner == PORT_D) && if_req;
    assign starve_clr = (grant && (winner == PORT_IF)) || ((state_q == ST_IDLE) && !if_req);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .WIDTH (4)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (starve_hit)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        wr_d        = wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    ram_en_d = 1'b1;
                    lat_d    = LAT_C;
                    if (winner == PORT_D) begin
                        ram_we_d    = d_we;
                        wr_d        = d_we;
                        ram_addr_d  = d_addr;
                        ram_wdata_d = d_wdata;
                        state_d     = ST_WAIT_D;
                    end else begin
                        wr_d       = 1'b0;
                        ram_addr_d = if_addr;
                        state_d    = ST_WAIT_IF;
                    end
                end
            end

            ST_WAIT_IF, ST_WAIT_D: begin
                lat_d = lat_q - 3'd1;
                // Counter is about to reach zero: RAM data is usable now.
                if (lat_q == 3'd1) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_WAIT_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = ram_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!wr_q) begin
                            d_rdata_d = ram_rdata;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            wr_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            wr_q        <= wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;

    assign if_stall = if_req & ~if_valid_q;
    assign d_stall  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Two arbiter lanes (LATENCY = 1 and LATENCY = 3, STARVE_LIMIT = 4), each with
// its own RAM and a transaction-timeline reference model compared every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req   [2];
    logic [31:0] if_addr  [2];
    logic [31:0] if_rdata [2];
    logic        if_valid [2];
    logic        if_stall [2];
    logic        d_req    [2];
    logic        d_we     [2];
    logic [31:0] d_addr   [2];
    logic [31:0] d_wdata  [2];
    logic [31:0] d_rdata  [2];
    logic        d_valid  [2];
    logic        d_stall  [2];
    logic        ram_en   [2];
    logic        ram_we   [2];
    logic [31:0] ram_addr [2];
    logic [31:0] ram_wdata[2];
    logic [31:0] ram_rdata[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)  return 32'hDEADBEEF;   // byte address 0x10
        if (i == 16) return 32'hCAFE0040;   // byte address 0x40
        return {8'hA5, 8'(i), 16'(i * 37)};
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int L = (k == 0) ? 1 : 3;

        unified_mem_arbiter #(
            .ADDR_WIDTH   (32),
            .DATA_WIDTH   (32),
            .LATENCY      (L),
            .STARVE_LIMIT (SL)
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .if_req    (if_req[k]),
            .if_addr   (if_addr[k]),
            .if_rdata  (if_rdata[k]),
            .if_valid  (if_valid[k]),
            .if_stall  (if_stall[k]),
            .d_req     (d_req[k]),
            .d_we      (d_we[k]),
            .d_addr    (d_addr[k]),
            .d_wdata   (d_wdata[k]),
            .d_rdata   (d_rdata[k]),
            .d_valid   (d_valid[k]),
            .d_stall   (d_stall[k]),
            .ram_en    (ram_en[k]),
            .ram_we    (ram_we[k]),
            .ram_addr  (ram_addr[k]),
            .ram_wdata (ram_wdata[k]),
            .ram_rdata (ram_rdata[k])
        );

        // RAM: read data follows the held address; writes land on the strobe edge.
        logic [31:0] ram [256];
        bit          ram_init = 1'b0;
        assign ram_rdata[k] = ram[ram_addr[k][9:2]];
        always @(posedge clk) begin
            if (!ram_init) begin
                for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
                ram_init <= 1'b1;
            end else if (ram_en[k] && ram_we[k]) begin
                ram[ram_addr[k][9:2]] <= ram_wdata[k];
            end
        end

        // Reference model: a grant decided in cycle c strobes the RAM in c+1 and
        // completes in c+1+L; nothing new is granted until the cycle after that.
        logic [31:0] m_mem [256];
        bit          m_init = 1'b0;
        int          cyc = 0;
        int          m_done = -1;
        int          m_starve = 0;
        bit          m_idle;
        logic        m_port_d, m_wr;
        logic [31:0] m_rd;
        logic        e_ram_en, e_ram_we, e_if_valid, e_d_valid;
        logic [31:0] e_ram_addr, e_ram_wdata, e_if_rdata, e_d_rdata;

        always @(posedge clk or posedge rst) begin
            if (!m_init) begin
                for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
                m_init = 1'b1;
            end
            if (rst) begin
                {e_ram_en, e_ram_we, e_if_valid, e_d_valid} = '0;
                e_ram_addr = '0; e_ram_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
                m_done = -1;
                m_starve = 0;
            end else begin
                {e_ram_en, e_ram_we, e_if_valid, e_d_valid} = '0;
                if (cyc + 1 == m_done) begin
                    if (m_port_d) begin
                        e_d_valid = 1'b1;
                        if (!m_wr) e_d_rdata = m_rd;
                    end else begin
                        e_if_valid = 1'b1;
                        e_if_rdata = m_rd;
                    end
                end
                m_idle = (cyc >= m_done);
                if (cyc > m_done && (if_req[k] || d_req[k])) begin
                    e_ram_en = 1'b1;
                    if (d_req[k] && !(if_req[k] && m_starve == SL)) begin
                        if (if_req[k]) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                        m_port_d    = 1'b1;
                        m_wr        = d_we[k];
                        e_ram_we    = d_we[k];
                        e_ram_addr  = d_addr[k];
                        e_ram_wdata = d_wdata[k];
                        if (d_we[k]) m_mem[d_addr[k][9:2]] = d_wdata[k];
                        else         m_rd = m_mem[d_addr[k][9:2]];
                    end else begin
                        m_starve   = 0;
                        m_port_d   = 1'b0;
                        m_wr       = 1'b0;
                        e_ram_addr = if_addr[k];
                        m_rd       = m_mem[if_addr[k][9:2]];
                    end
                    m_done = cyc + 1 + L;
                end
                if (m_idle && !if_req[k]) m_starve = 0;
                cyc++;
            end
        end

        always @(negedge clk) begin
            check($sformatf("lane%0d ram_en", k),    ram_en[k],    e_ram_en);
            check($sformatf("lane%0d ram_we", k),    ram_we[k],    e_ram_we);
            check($sformatf("lane%0d ram_addr", k),  ram_addr[k],  e_ram_addr);
            check($sformatf("lane%0d ram_wdata", k), ram_wdata[k], e_ram_wdata);
            check($sformatf("lane%0d if_valid", k),  if_valid[k],  e_if_valid);
            check($sformatf("lane%0d d_valid", k),   d_valid[k],   e_d_valid);
            check($sformatf("lane%0d if_rdata", k),  if_rdata[k],  e_if_rdata);
            check($sformatf("lane%0d d_rdata", k),   d_rdata[k],   e_d_rdata);
            check($sformatf("lane%0d if_stall", k),  if_stall[k],  if_req[k] & ~e_if_valid);
            check($sformatf("lane%0d d_stall", k),   d_stall[k],   d_req[k] & ~e_d_valid);
        end
    end

    // Inputs change 1 ns after the falling edge, well away from the sampling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int k, input int port, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            step();
            n++;
            got = (port == 0) ? if_valid[k] : d_valid[k];
        end
        check($sformatf("lane%0d port%0d completes", k, port), got, 1'b1);
    endtask

    task automatic lone_fetch(input int k);
        int L;
        L = lat_of(k);
        if_addr[k] = 32'h10;
        if_req[k]  = 1'b1;
        #1;
        check("lone if_stall T0", if_stall[k], 1'b1);
        for (int i = 1; i <= L + 1; i++) begin
            step();
            check($sformatf("lone lane%0d ram_en T%0d", k, i),   ram_en[k],   i == 1);
            check($sformatf("lone lane%0d if_valid T%0d", k, i), if_valid[k], i == L + 1);
            check($sformatf("lone lane%0d if_stall T%0d", k, i), if_stall[k], i != L + 1);
        end
        check("lone if_rdata", if_rdata[k], 32'hDEADBEEF);
        if_req[k] = 1'b0;
        step();
    endtask

    task automatic both_req(input int k);
        int L;
        L = lat_of(k);
        d_addr[k]  = 32'h40;
        d_we[k]    = 1'b0;
        if_addr[k] = 32'h04;
        d_req[k]   = 1'b1;
        if_req[k]  = 1'b1;
        for (int i = 1; i <= 3 + 2 * L; i++) begin
            step();
            check($sformatf("both lane%0d d_valid T%0d", k, i),  d_valid[k],  i == 1 + L);
            check($sformatf("both lane%0d if_valid T%0d", k, i), if_valid[k], i == 3 + 2 * L);
            check($sformatf("both lane%0d ram_en T%0d", k, i),   ram_en[k],   (i == 1) || (i == 3 + L));
            if (i == 1 + L) begin
                check("both d_rdata", d_rdata[k], 32'hCAFE0040);
                d_req[k] = 1'b0;
            end
            if (i == 3 + 2 * L) begin
                check("both if_rdata", if_rdata[k], 32'hA5010025);
                if_req[k] = 1'b0;
            end
        end
        step();
    endtask

    task automatic store_load(input int k);
        int n;
        d_addr[k]  = 32'h80;
        d_wdata[k] = 32'h12345678;
        d_we[k]    = 1'b1;
        d_req[k]   = 1'b1;
        wait_valid(k, 1, n);
        check("store latency", n, lat_of(k) + 1);
        check("store keeps d_rdata", d_rdata[k], 32'hCAFE0040);
        d_req[k] = 1'b0;
        step();
        d_we[k]  = 1'b0;
        d_req[k] = 1'b1;
        wait_valid(k, 1, n);
        check("load after store", d_rdata[k], 32'h12345678);
        d_req[k] = 1'b0;
        step();
    endtask

    task automatic starve(input int k);
        logic [9:0] pat;
        int n;
        pat = '0;
        n = 0;
        if_addr[k] = 32'h08;
        d_addr[k]  = 32'h0C;
        d_we[k]    = 1'b0;
        if_req[k]  = 1'b1;
        d_req[k]   = 1'b1;
        for (int c = 0; c < 200 && n < 10; c++) begin
            step();
            if (d_valid[k]) begin
                pat[9 - n] = 1'b1;
                n++;
            end else if (if_valid[k]) begin
                n++;
            end
        end
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
        check($sformatf("starve lane%0d completions", k), n, 10);
        check($sformatf("starve lane%0d order D=1", k), pat, 10'b1111011110);
        step();
        step();
    endtask

    task automatic reset_mid(input int k);
        int L;
        L = lat_of(k);
        d_addr[k] = 32'h44;
        d_we[k]   = 1'b0;
        d_req[k]  = 1'b1;
        step();
        step();
        step();
        check("pre-reset d_valid", d_valid[k], 1'b0);
        rst      = 1'b1;
        d_req[k] = 1'b0;
        #1;
        check("async rst ram_en",    ram_en[k],    1'b0);
        check("async rst ram_we",    ram_we[k],    1'b0);
        check("async rst ram_addr",  ram_addr[k],  32'h0);
        check("async rst ram_wdata", ram_wdata[k], 32'h0);
        check("async rst if_valid",  if_valid[k],  1'b0);
        check("async rst d_valid",   d_valid[k],   1'b0);
        check("async rst if_rdata",  if_rdata[k],  32'h0);
        check("async rst d_rdata",   d_rdata[k],   32'h0);
        step();
        rst        = 1'b0;
        if_addr[k] = 32'h10;
        if_req[k]  = 1'b1;
        for (int i = 1; i <= L + 1; i++) begin
            step();
            check($sformatf("post-rst d_valid T%0d", i),  d_valid[k],  1'b0);
            check($sformatf("post-rst ram_en T%0d", i),   ram_en[k],   i == 1);
            check($sformatf("post-rst if_valid T%0d", i), if_valid[k], i == L + 1);
        end
        check("post-rst if_rdata", if_rdata[k], 32'hDEADBEEF);
        if_req[k] = 1'b0;
        step();
    endtask

    task automatic random_port(input int k, input int port);
        int n;
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) step();
            if (port == 0) begin
                if_addr[k] = {22'b0, 8'($urandom), 2'b00};
                if_req[k]  = 1'b1;
            end else begin
                d_addr[k]  = {22'b0, 8'($urandom), 2'b00};
                d_we[k]    = 1'($urandom_range(0, 1));
                d_wdata[k] = $urandom;
                d_req[k]   = 1'b1;
            end
            wait_valid(k, port, n);
            if (port == 0) if_req[k] = 1'b0;
            else           d_req[k]  = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k]  = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset lane0 if_rdata", if_rdata[0], 32'h0);
        check("reset lane1 ram_en",   ram_en[1],   1'b0);

        lone_fetch(0);
        lone_fetch(1);
        both_req(0);
        both_req(1);
        store_load(0);
        starve(0);
        starve(1);
        reset_mid(1);

        fork
            random_port(0, 0);
            random_port(0, 1);
            random_port(1, 0);
            random_port(1, 1);
        join
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
